wb_arbiter: RTL



---
 rtl/wb_arb_pkg.sv | 16 +
 rtl/wb_fifo.sv | 61 ++++++
 rtl/wb_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and default widths for the write-back arbiter and its FIFOs.
package wb_arb_pkg;

    localparam int unsigned WB_DATA_W = 32;
    localparam int unsigned WB_TAG_W  = 4;
    localparam int unsigned WB_RD_W   = 5;

    localparam logic [WB_TAG_W-1:0] TAG_INVALID = '0;

    typedef struct packed {
        logic [WB_DATA_W-1:0] data;
        logic [WB_TAG_W-1:0]  tag;
        logic [WB_RD_W-1:0]   rd;
    } WbEntry;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous per-requester result FIFO; DEPTH must be a power of two so the
// pointers wrap naturally. flush empties it in one cycle.
module wb_fifo
    import wb_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter type         T     = WbEntry
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic pop,
    input  logic flush,
    input  T     din,
    output logic full,
    output logic empty,
    output T     head
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Payload storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin write-back arbiter: per-requester FIFOs feeding one registered
// write-back port. Optional flush port enabled by WB_ARB_FLUSH_EN.
module wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned N_REQ  = 3,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned RD_W   = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*TAG_W-1:0]  req_tag,
    input  logic [N_REQ*RD_W-1:0]   req_rd,
    input  logic [N_REQ*DATA_W-1:0] req_data,
`ifdef WB_ARB_FLUSH_EN
    input  logic                    flush,
`endif
    output logic                    wb_valid,
    output logic [TAG_W-1:0]        wb_tag,
    output logic [RD_W-1:0]         wb_rd,
    output logic [DATA_W-1:0]       wb_data
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
        logic [RD_W-1:0]   rd;
    } entry_t;

    logic             do_flush;
    logic [N_REQ-1:0] push;
    logic [N_REQ-1:0] pop;
    logic [N_REQ-1:0] full;
    logic [N_REQ-1:0] empty;
    entry_t           din  [N_REQ];
    entry_t           head [N_REQ];
    logic [IDX_W-1:0] rr;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;

`ifdef WB_ARB_FLUSH_EN
    assign do_flush = flush;
`else
    assign do_flush = 1'b0;
`endif

    assign req_ready = ~full;

    for (genvar i = 0; i < N_REQ; i++) begin : g_req
        assign din[i] = '{data: req_data[i*DATA_W +: DATA_W],
                          tag:  req_tag[i*TAG_W +: TAG_W],
                          rd:   req_rd[i*RD_W +: RD_W]};

        // Dead results complete their handshake but never occupy a slot.
        assign push[i] = req_valid[i] && !full[i]
                         && (din[i].tag != TAG_W'(TAG_INVALID))
                         && (din[i].rd != '0);
        assign pop[i]  = gnt_valid && (gnt_idx == IDX_W'(i));

        wb_fifo #(
            .DEPTH (DEPTH),
            .T     (entry_t)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[i]),
            .pop   (pop[i]),
            .flush (do_flush),
            .din   (din[i]),
            .full  (full[i]),
            .empty (empty[i]),
            .head  (head[i])
        );
    end

    // First non-empty FIFO scanning upward from rr, wrapping at N_REQ.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = rr;
        cand      = rr;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            cand = IDX_W'((32'(rr) + off) % N_REQ);
            if (!gnt_valid && !empty[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr       <= '0;
            wb_valid <= 1'b0;
            wb_tag   <= TAG_W'(TAG_INVALID);
            wb_rd    <= '0;
            wb_data  <= '0;
        end else if (do_flush || !gnt_valid) begin
            wb_valid <= 1'b0;
            wb_tag   <= TAG_W'(TAG_INVALID);
            wb_rd    <= '0;
            wb_data  <= '0;
        end else begin
            rr       <= (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            wb_valid <= 1'b1;
            wb_tag   <= head[gnt_idx].tag;
            wb_rd    <= head[gnt_idx].rd;
            wb_data  <= head[gnt_idx].data;
        end
    end

endmodule
